tmr_vote_monitor: RTL and testbench

- Consumes the three domain copies of a triplicated register bank and produces one registered majority-voted word.
- Detects, per lane, which copy disagrees with the vote and keeps per-lane saturating error counters.
- Raises sticky persistent-fault flags for a lane that stays wrong for PERSIST consecutive cycles.
- Sits directly downstream of the triplicated flops, at the boundary where TMR logic feeds non-triplicated logic or a status/scrub controller.

---
 rtl/tmr_mon_pkg.sv | 16 +
 rtl/tmr_lane_tracker.sv | 70 +++++++
 rtl/tmr_vote_monitor.sv | 101 ++++++++++
 tb/tb_tmr_vote_monitor.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_mon_pkg.sv
// Shared definitions for the TMR vote monitor.
// Holds the lane indices and the run-counter width helper.
package tmr_mon_pkg;

    // Lane indices into packed per-lane vectors
    localparam int LANE_A = 0;
    localparam int LANE_B = 1;
    localparam int LANE_C = 2;
    localparam int NUM_LANES = 3;

    // Width of a counter that must hold the values 0..persist
    function automatic int run_width(input int persist);
        return (persist < 1) ? 1 : $clog2(persist + 1);
    endfunction

endpackage

// File: rtl/tmr_lane_tracker.sv
// Per-lane error bookkeeping: saturating mismatch count,
// consecutive-mismatch run length and a sticky fault flag.
module tmr_lane_tracker
    import tmr_mon_pkg::*;
#(
    parameter int CNT_WIDTH = 4,
    parameter int PERSIST   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mis,
    input  logic                 en,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 fault
);

    localparam int RUN_W = run_width(PERSIST);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [RUN_W-1:0]     RUN_MAX = RUN_W'(PERSIST);
    localparam logic [RUN_W-1:0]     RUN_ONE = RUN_W'(1);
    localparam logic [RUN_W-1:0]     RUN_TRIP = RUN_W'(PERSIST - 1);

    logic [CNT_WIDTH-1:0] cnt_b;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [RUN_W-1:0]     run_q;
    logic [RUN_W-1:0]     run_b;
    logic [RUN_W-1:0]     run_d;
    logic                 fault_b;
    logic                 fault_d;

    // Clear first, then fold in this cycle's event so none is lost
    always_comb begin
        cnt_b   = clr ? '0 : cnt;
        run_b   = clr ? '0 : run_q;
        fault_b = clr ? 1'b0 : fault;
        cnt_d   = cnt_b;
        run_d   = run_b;
        fault_d = fault_b;
        if (en && mis) begin
            if (cnt_b != CNT_MAX) begin
                cnt_d = cnt_b + CNT_ONE;
            end
            if (run_b != RUN_MAX) begin
                run_d = run_b + RUN_ONE;
            end
            if (run_b >= RUN_TRIP) begin
                fault_d = 1'b1;
            end
        end else if (en) begin
            run_d = '0;
        end
    end

    // Tracker state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            run_q <= '0;
            fault <= 1'b0;
        end else begin
            cnt   <= cnt_d;
            run_q <= run_d;
            fault <= fault_d;
        end
    end

endmodule

// File: rtl/tmr_vote_monitor.sv
// Majority voter for a triplicated register bank with per-lane
// mismatch detection, saturating error counts and fault flags.
module tmr_vote_monitor
    import tmr_mon_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 4,
    parameter int PERSIST   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     inA,
    input  logic [WIDTH-1:0]     inB,
    input  logic [WIDTH-1:0]     inC,
    input  logic                 en,
    input  logic                 clr,
    output logic [WIDTH-1:0]     voted,
    output logic                 errA,
    output logic                 errB,
    output logic                 errC,
    output logic                 multiErr,
    output logic [CNT_WIDTH-1:0] cntA,
    output logic [CNT_WIDTH-1:0] cntB,
    output logic [CNT_WIDTH-1:0] cntC,
    output logic                 faultA,
    output logic                 faultB,
    output logic                 faultC
);

    logic [WIDTH-1:0]     voted_c;
    logic [NUM_LANES-1:0] mis_c;
    logic                 multi_c;

    // Bitwise majority and per-lane disagreement with it
    always_comb begin
        voted_c        = (inA & inB) | (inA & inC) | (inB & inC);
        mis_c[LANE_A]  = |(inA ^ voted_c);
        mis_c[LANE_B]  = |(inB ^ voted_c);
        mis_c[LANE_C]  = |(inC ^ voted_c);
        multi_c        = (mis_c[LANE_A] & mis_c[LANE_B])
                       | (mis_c[LANE_A] & mis_c[LANE_C])
                       | (mis_c[LANE_B] & mis_c[LANE_C]);
    end

    // Vote and mismatch flags register every cycle, independent of en/clr
    always_ff @(posedge clk) begin
        if (rst) begin
            voted    <= '0;
            errA     <= 1'b0;
            errB     <= 1'b0;
            errC     <= 1'b0;
            multiErr <= 1'b0;
        end else begin
            voted    <= voted_c;
            errA     <= mis_c[LANE_A];
            errB     <= mis_c[LANE_B];
            errC     <= mis_c[LANE_C];
            multiErr <= multi_c;
        end
    end

    tmr_lane_tracker #(
        .CNT_WIDTH (CNT_WIDTH),
        .PERSIST   (PERSIST)
    ) u_lane_a (
        .clk   (clk),
        .rst   (rst),
        .mis   (mis_c[LANE_A]),
        .en    (en),
        .clr   (clr),
        .cnt   (cntA),
        .fault (faultA)
    );

    tmr_lane_tracker #(
        .CNT_WIDTH (CNT_WIDTH),
        .PERSIST   (PERSIST)
    ) u_lane_b (
        .clk   (clk),
        .rst   (rst),
        .mis   (mis_c[LANE_B]),
        .en    (en),
        .clr   (clr),
        .cnt   (cntB),
        .fault (faultB)
    );

    tmr_lane_tracker #(
        .CNT_WIDTH (CNT_WIDTH),
        .PERSIST   (PERSIST)
    ) u_lane_c (
        .clk   (clk),
        .rst   (rst),
        .mis   (mis_c[LANE_C]),
        .en    (en),
        .clr   (clr),
        .cnt   (cntC),
        .fault (faultC)
    );

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Self-checking bench for tmr_vote_monitor: behavioural model
// compared every cycle plus directed literal expectations.
module tb_tmr_vote_monitor;

    localparam int W  = 8;
    localparam int CW = 4;
    localparam int P  = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  inA, inB, inC;
    logic          en, clr;
    logic [W-1:0]  voted;
    logic          errA, errB, errC, multiErr;
    logic [CW-1:0] cntA, cntB, cntC;
    logic          faultA, faultB, faultC;

    int checks = 0;
    int failures = 0;
    bit started = 1'b0;

    // Model state
    int m_voted;
    int m_err   [3];
    int m_multi;
    int m_cnt   [3];
    int m_run   [3];
    int m_fault [3];

    tmr_vote_monitor #(
        .WIDTH     (W),
        .CNT_WIDTH (CW),
        .PERSIST   (P)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .inA      (inA),
        .inB      (inB),
        .inC      (inC),
        .en       (en),
        .clr      (clr),
        .voted    (voted),
        .errA     (errA),
        .errB     (errB),
        .errC     (errC),
        .multiErr (multiErr),
        .cntA     (cntA),
        .cntB     (cntB),
        .cntC     (cntC),
        .faultA   (faultA),
        .faultB   (faultB),
        .faultC   (faultC)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: majority by counting votes per bit, lanes by equality
    always @(posedge clk) begin
        int copies [3];
        int maj;
        int nmis;
        int mis [3];
        copies[0] = int'(inA);
        copies[1] = int'(inB);
        copies[2] = int'(inC);
        maj = 0;
        for (int b = 0; b < W; b++) begin
            int ones;
            ones = 0;
            for (int l = 0; l < 3; l++) ones += (copies[l] >> b) & 1;
            if (ones >= 2) maj += (1 << b);
        end
        nmis = 0;
        for (int l = 0; l < 3; l++) begin
            mis[l] = (copies[l] != maj) ? 1 : 0;
            nmis += mis[l];
        end
        if (rst) begin
            m_voted = 0;
            m_multi = 0;
            for (int l = 0; l < 3; l++) begin
                m_err[l] = 0; m_cnt[l] = 0;
                m_run[l] = 0; m_fault[l] = 0;
            end
        end else begin
            m_voted = maj;
            m_multi = (nmis >= 2) ? 1 : 0;
            for (int l = 0; l < 3; l++) begin
                m_err[l] = mis[l];
                if (clr) begin
                    m_cnt[l] = 0; m_run[l] = 0; m_fault[l] = 0;
                end
                if (en) begin
                    if (mis[l] != 0) begin
                        if (m_cnt[l] < CMAX) m_cnt[l]++;
                        if (m_run[l] < P) m_run[l]++;
                        if (m_run[l] == P) m_fault[l] = 1;
                    end else begin
                        m_run[l] = 0;
                    end
                end
            end
        end
        started = 1'b1;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            chk("voted", int'(voted), m_voted);
            chk("errA", int'(errA), m_err[0]);
            chk("errB", int'(errB), m_err[1]);
            chk("errC", int'(errC), m_err[2]);
            chk("multiErr", int'(multiErr), m_multi);
            chk("cntA", int'(cntA), m_cnt[0]);
            chk("cntB", int'(cntB), m_cnt[1]);
            chk("cntC", int'(cntC), m_cnt[2]);
            chk("faultA", int'(faultA), m_fault[0]);
            chk("faultB", int'(faultB), m_fault[1]);
            chk("faultC", int'(faultC), m_fault[2]);
        end
    end

    task automatic step(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic e,
                        input logic cl, input logic r);
        inA = a; inB = b; inC = c;
        en = e; clr = cl; rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) step(8'hA5, 8'hA5, 8'hA5, 1, 0, 0);
    endtask

    initial begin
        inA = 8'hFF; inB = 8'h0F; inC = 8'hF0;
        en = 1'b1; clr = 1'b0; rst = 1'b1;
        step(8'hFF, 8'h0F, 8'hF0, 1, 0, 1);
        step(8'hFF, 8'h0F, 8'hF0, 1, 1, 1);
        chk("reset voted", int'(voted), 0);
        chk("reset errA", int'(errA), 0);

        // Clean stream
        clean(10);
        chk("clean voted", int'(voted), 8'hA5);
        chk("clean cntB", int'(cntB), 0);

        // Single upset on B
        step(8'hA5, 8'hA4, 8'hA5, 1, 0, 0);
        chk("upset voted", int'(voted), 8'hA5);
        chk("upset errB", int'(errB), 1);
        chk("upset cntB", int'(cntB), 1);
        chk("upset faultB", int'(faultB), 0);
        clean(1);
        chk("upset errB clr", int'(errB), 0);

        // Persistent fault on C
        step(8'hA5, 8'hA5, 8'h00, 1, 0, 0);
        step(8'hA5, 8'hA5, 8'h00, 1, 0, 0);
        chk("persist2 faultC", int'(faultC), 0);
        step(8'hA5, 8'hA5, 8'h00, 1, 0, 0);
        chk("persist3 faultC", int'(faultC), 1);
        clean(2);
        chk("sticky faultC", int'(faultC), 1);
        chk("sticky cntC", int'(cntC), 3);

        // Broken run never faults
        step(8'hA5, 8'hA5, 8'hA5, 1, 1, 0);
        chk("clr faultC", int'(faultC), 0);
        chk("clr cntC", int'(cntC), 0);
        for (int i = 0; i < 2; i++) step(8'hA5, 8'hA5, 8'h01, 1, 0, 0);
        clean(1);
        for (int i = 0; i < 2; i++) step(8'hA5, 8'hA5, 8'h01, 1, 0, 0);
        chk("broken faultC", int'(faultC), 0);
        chk("broken cntC", int'(cntC), 4);

        // Saturation on A
        step(8'hA5, 8'hA5, 8'hA5, 1, 1, 0);
        for (int i = 0; i < 20; i++) begin
            step(8'h5A, 8'hA5, 8'hA5, 1, 0, 0);
            if (i == 14) chk("sat cntA at 15", int'(cntA), 15);
        end
        chk("sat cntA hold", int'(cntA), 15);
        chk("sat faultA", int'(faultA), 1);

        // Two lanes wrong in different bits
        step(8'hA4, 8'hA7, 8'hA5, 1, 1, 0);
        chk("multi voted", int'(voted), 8'hA5);
        chk("multi errA", int'(errA), 1);
        chk("multi errB", int'(errB), 1);
        chk("multi errC", int'(errC), 0);
        chk("multi flag", int'(multiErr), 1);
        chk("multi cntA", int'(cntA), 1);

        // Build a fault on A, then clear with a same-edge mismatch
        step(8'hA4, 8'hA5, 8'hA5, 1, 0, 0);
        step(8'hA4, 8'hA5, 8'hA5, 1, 0, 0);
        chk("pre-clr faultA", int'(faultA), 1);
        step(8'hA4, 8'hA5, 8'hA5, 1, 1, 0);
        chk("clr+mis cntA", int'(cntA), 1);
        chk("clr+mis faultA", int'(faultA), 0);

        // Disabled: err tracks, counters and run hold
        step(8'hA4, 8'hA5, 8'hA5, 0, 0, 0);
        step(8'hA4, 8'hA5, 8'hA5, 0, 0, 0);
        chk("dis errA", int'(errA), 1);
        chk("dis cntA", int'(cntA), 1);
        chk("dis faultA", int'(faultA), 0);
        step(8'hA4, 8'hA5, 8'hA5, 1, 0, 0);
        chk("resume cntA", int'(cntA), 2);
        chk("resume faultA", int'(faultA), 0);

        // Reset mid-run discards everything
        step(8'hA4, 8'hA5, 8'hA5, 1, 0, 1);
        chk("rst voted", int'(voted), 0);
        chk("rst errA", int'(errA), 0);
        chk("rst cntA", int'(cntA), 0);
        chk("rst cntC", int'(cntC), 0);
        step(8'hA4, 8'hA5, 8'hA5, 1, 0, 0);
        chk("post-rst cntA", int'(cntA), 1);
        step(8'hA4, 8'hA5, 8'hA5, 1, 0, 0);
        chk("post-rst run faultA", int'(faultA), 0);
        clean(2);

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
